// File: rtl/pairing_vector_checker.sv
// Self-checking sequencer: feeds NVEC stored vectors to the pairing core, waits for
// each result (with timeout) and keeps pass/fail counters plus first-failure capture.
module pairing_vector_checker #(
  parameter int W       = 194,
  parameter int NVEC    = 4,
  parameter int IDX_W   = 2,
  parameter int CNT_W   = 3,
  parameter int TIMEOUT = 65535,
  parameter int TMR_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             stop_on_fail,
  output logic [IDX_W-1:0] vec_idx,
  input  logic [W-1:0]     vec_x1,
  input  logic [W-1:0]     vec_y1,
  input  logic [W-1:0]     vec_x2,
  input  logic [W-1:0]     vec_y2,
  input  logic [W-1:0]     vec_exp,
  output logic [W-1:0]     core_x1,
  output logic [W-1:0]     core_y1,
  output logic [W-1:0]     core_x2,
  output logic [W-1:0]     core_y2,
  output logic             core_start,
  input  logic             core_done,
  input  logic [W-1:0]     core_out,
  output logic             busy,
  output logic             done,
  output logic             all_ok,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [IDX_W-1:0] first_fail_idx,
  output logic             any_fail,
  output logic             timeout_seen
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PULSE, S_WAIT, S_CHECK, S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [TMR_W-1:0] timer;
  logic             done_q;
  logic             sof_q;
  logic             timed_out;
  logic [W-1:0]     exp_q;
  logic [W-1:0]     res_q;

  logic rise, tmo_hit, vec_pass, last_vec;

  // Only a fresh rising edge counts, so a done level left over from the previous vector is ignored.
  assign rise     = core_done & ~done_q;
  assign tmo_hit  = (timer == TMR_W'(TIMEOUT - 1));
  assign vec_pass = (res_q == exp_q) && !timed_out;
  assign last_vec = (idx == IDX_W'(NVEC - 1));

  assign vec_idx    = idx;
  assign core_start = (state == S_PULSE);
  assign busy       = (state != S_IDLE) && (state != S_DONE);
  assign done       = (state == S_DONE);
  assign all_ok     = done && (fail_cnt == '0) && (pass_cnt == CNT_W'(NVEC));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (go) state_nxt = S_LOAD;
      S_LOAD:         state_nxt = S_PULSE;
      S_PULSE:        state_nxt = S_WAIT;
      S_WAIT:         if (rise || tmo_hit) state_nxt = S_CHECK;
      S_CHECK:        state_nxt = (last_vec || (!vec_pass && sof_q)) ? S_DONE : S_LOAD;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx            <= '0;
      timer          <= '0;
      done_q         <= 1'b0;
      sof_q          <= 1'b0;
      timed_out      <= 1'b0;
      exp_q          <= '0;
      res_q          <= '0;
      core_x1        <= '0;
      core_y1        <= '0;
      core_x2        <= '0;
      core_y2        <= '0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_idx <= '0;
      any_fail       <= 1'b0;
      timeout_seen   <= 1'b0;
    end else begin
      done_q <= core_done;
      case (state)
        S_IDLE, S_DONE: begin
          if (go) begin
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_idx <= '0;
            any_fail       <= 1'b0;
            timeout_seen   <= 1'b0;
            idx            <= '0;
            sof_q          <= stop_on_fail;
          end
        end
        S_LOAD: begin
          core_x1 <= vec_x1;
          core_y1 <= vec_y1;
          core_x2 <= vec_x2;
          core_y2 <= vec_y2;
          exp_q   <= vec_exp;
        end
        S_PULSE: begin
          timer     <= '0;
          timed_out <= 1'b0;
        end
        S_WAIT: begin
          if (rise)         res_q     <= core_out;
          else if (tmo_hit) timed_out <= 1'b1;
          else              timer     <= timer + 1'b1;
        end
        S_CHECK: begin
          if (vec_pass) begin
            pass_cnt <= pass_cnt + 1'b1;
          end else begin
            fail_cnt <= fail_cnt + 1'b1;
            if (!any_fail) begin
              first_fail_idx <= idx;
              any_fail       <= 1'b1;
            end
            if (timed_out) timeout_seen <= 1'b1;
          end
          if (!(last_vec || (!vec_pass && sof_q))) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
